// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
// Shared constants, helpers and types for the shared AND/XOR logic unit
// arbiter. Imported by lu_rr_pick and logic_unit_arbiter.
//   LU_NUM_REQ / LU_WIDTH  default requester count and operand width
//   lu_id_w()              width of a requester ID for a given count
//   lu_rsp_t               response register payload {id, and_r, xor_r}
package logic_unit_pkg;

    localparam int LU_NUM_REQ   = 4;
    localparam int LU_WIDTH     = 8;

    // The response struct is sized for the largest supported configuration
    // (8 requesters, 32-bit operands); narrower instances zero-extend into it
    // and slice their own width back out.
    localparam int LU_MAX_ID_W  = 3;
    localparam int LU_MAX_WIDTH = 32;

    function automatic int lu_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [LU_MAX_ID_W-1:0]  id;
        logic [LU_MAX_WIDTH-1:0] and_r;
        logic [LU_MAX_WIDTH-1:0] xor_r;
    } lu_rsp_t;

endpackage

// File: rtl/lu_rr_pick.sv
// lu_rr_pick
// Combinational round-robin picker. Searches upward from last_grant_i+1,
// wrapping modulo NUM_REQ, for the first set request bit.
//   req_i         request vector
//   last_grant_i  index of the previously granted requester
//   grant_o       one-hot grant (all zero if no request)
//   grant_idx_o   encoded index of the grant (0 if no request)
module lu_rr_pick
    import logic_unit_pkg::*;
#(
    parameter int NUM_REQ = LU_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o
);

    localparam int ID_W = lu_id_w(NUM_REQ);

    logic [NUM_REQ-1:0] rotated;
    logic [ID_W-1:0]    srcIdx;
    logic [ID_W-1:0]    winIdx;
    logic               found;
    int                 startIdx;
    int                 firstIdx;

    // Rotate the requests so the highest-priority requester sits at bit 0,
    // take the lowest set bit, then rotate the winner's position back.
    always_comb begin
        rotated     = '0;
        srcIdx      = '0;
        winIdx      = '0;
        found       = 1'b0;
        firstIdx    = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        startIdx    = (int'(last_grant_i) + 1) % NUM_REQ;

        for (int i = 0; i < NUM_REQ; i++) begin
            srcIdx     = ID_W'((i + startIdx) % NUM_REQ);
            rotated[i] = req_i[srcIdx];
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rotated[i]) begin
                found    = 1'b1;
                firstIdx = i;
            end
        end

        if (found) begin
            winIdx          = ID_W'((firstIdx + startIdx) % NUM_REQ);
            grant_o[winIdx] = 1'b1;
            grant_idx_o     = winIdx;
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
// Shares one registered bitwise AND/XOR unit between NUM_REQ requesters.
// Round-robin arbitration, one acceptance per cycle, results returned with
// the owning requester ID over a valid/ready response channel.
//   clk, rst      clock, asynchronous active-high reset
//   req_valid     per-requester operand valid
//   req_a, req_b  packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready     one-hot accept strobe (combinational)
//   rsp_valid     response register holds a result
//   rsp_ready     downstream accepts the response
//   rsp_id        requester owning the response
//   rsp_and       a & b
//   rsp_xor       a ^ b
//   grant_count   accepted requests since reset, wraps silently
// WIDTH must not exceed LU_MAX_WIDTH and NUM_REQ must be 2..8.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int NUM_REQ = LU_NUM_REQ,
    parameter int WIDTH   = LU_WIDTH,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_and,
    output logic [WIDTH-1:0]           rsp_xor,
    output logic [CNT_W-1:0]           grant_count
);

    localparam int ID_W = lu_id_w(NUM_REQ);

    lu_rsp_t            rsp_q, rsp_d;
    logic               rspValid_q, rspValid_d;
    logic [ID_W-1:0]    lastGrant_q, lastGrant_d;
    logic [CNT_W-1:0]   grantCount_q, grantCount_d;

    logic [NUM_REQ-1:0] pickOneHot;
    logic [ID_W-1:0]    pickIdx;
    logic               slotFree;
    logic               grantEn;
    logic [WIDTH-1:0]   opA;
    logic [WIDTH-1:0]   opB;
    logic               unusedRsp;

    lu_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req_i       (req_valid),
        .last_grant_i(lastGrant_q),
        .grant_o     (pickOneHot),
        .grant_idx_o (pickIdx)
    );

    // A grant needs a free response slot: either it is empty or it drains
    // this cycle. rst gates req_ready so nothing looks accepted during reset.
    always_comb begin
        slotFree  = !rspValid_q || rsp_ready;
        grantEn   = slotFree && (|req_valid) && !rst;
        req_ready = grantEn ? pickOneHot : '0;
        opA       = req_a[pickIdx*WIDTH +: WIDTH];
        opB       = req_b[pickIdx*WIDTH +: WIDTH];
    end

    // Next state: a grant loads a fresh result (even while the old one
    // drains); a drain without a grant only clears valid so the data fields
    // keep their last values.
    always_comb begin
        rsp_d        = rsp_q;
        rspValid_d   = rspValid_q;
        lastGrant_d  = lastGrant_q;
        grantCount_d = grantCount_q;

        if (grantEn) begin
            rsp_d.id     = LU_MAX_ID_W'(pickIdx);
            rsp_d.and_r  = LU_MAX_WIDTH'(opA & opB);
            rsp_d.xor_r  = LU_MAX_WIDTH'(opA ^ opB);
            rspValid_d   = 1'b1;
            lastGrant_d  = pickIdx;
            grantCount_d = grantCount_q + CNT_W'(1);
        end else if (rspValid_q && rsp_ready) begin
            rspValid_d   = 1'b0;
        end
    end

    // Pointer resets to the last requester so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_q        <= '0;
            rspValid_q   <= 1'b0;
            lastGrant_q  <= ID_W'(NUM_REQ - 1);
            grantCount_q <= '0;
        end else begin
            rsp_q        <= rsp_d;
            rspValid_q   <= rspValid_d;
            lastGrant_q  <= lastGrant_d;
            grantCount_q <= grantCount_d;
        end
    end

    // Upper struct bits beyond this instance's widths are always zero.
    assign unusedRsp   = ^rsp_q;

    assign rsp_valid   = rspValid_q;
    assign rsp_id      = rsp_q.id[ID_W-1:0];
    assign rsp_and     = rsp_q.and_r[WIDTH-1:0];
    assign rsp_xor     = rsp_q.xor_r[WIDTH-1:0];
    assign grant_count = grantCount_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter
// Directed, table-driven bench for logic_unit_arbiter (NUM_REQ=4, WIDTH=8).
// The grant counter is narrowed to 4 bits so its wrap can be reached quickly.
module tb_logic_unit_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int CW   = 4;

    localparam logic [31:0] DEF_A = 32'h3F2F1F0F;
    localparam logic [31:0] DEF_B = 32'h55555555;
    localparam logic [31:0] SP_A  = 32'h3FF01F0F;
    localparam logic [31:0] SP_B  = 32'h553C5555;

    logic              clock;
    logic              reset;
    logic [NREQ-1:0]   reqValid;
    logic [NREQ*W-1:0] reqA;
    logic [NREQ*W-1:0] reqB;
    logic [NREQ-1:0]   reqReady;
    logic              rspValid;
    logic              rspReady;
    logic [1:0]        rspId;
    logic [W-1:0]      rspAnd;
    logic [W-1:0]      rspXor;
    logic [CW-1:0]     grantCount;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        logic        rdy;
        logic [3:0]  expReady;
        logic        expValid;
        logic [1:0]  expId;
        logic [7:0]  expAnd;
        logic [7:0]  expXor;
        logic [3:0]  expCount;
    } vec_t;

    vec_t vecs[21];

    logic_unit_arbiter #(
        .NUM_REQ(NREQ),
        .WIDTH  (W),
        .CNT_W  (CW)
    ) dut (
        .clk        (clock),
        .rst        (reset),
        .req_valid  (reqValid),
        .req_a      (reqA),
        .req_b      (reqB),
        .req_ready  (reqReady),
        .rsp_valid  (rspValid),
        .rsp_ready  (rspReady),
        .rsp_id     (rspId),
        .rsp_and    (rspAnd),
        .rsp_xor    (rspXor),
        .grant_count(grantCount)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] a,
                                 input logic [31:0] b, input logic r);
        reqValid = v;
        reqA     = a;
        reqB     = b;
        rspReady = r;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checkCount++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            passCount++;
    endtask

    // Response-side checks taken #1 after a rising edge.
    task automatic checkRsp(input string tag, input logic v, input logic [1:0] id,
                            input logic [7:0] an, input logic [7:0] xo,
                            input logic [3:0] cnt);
        checkOutput({tag, ".rsp_valid"}, 32'(rspValid), 32'(v));
        checkOutput({tag, ".rsp_id"}, 32'(rspId), 32'(id));
        checkOutput({tag, ".rsp_and"}, 32'(rspAnd), 32'(an));
        checkOutput({tag, ".rsp_xor"}, 32'(rspXor), 32'(xo));
        checkOutput({tag, ".grant_count"}, 32'(grantCount), 32'(cnt));
    endtask

    initial begin
        // Each row is one cycle: inputs, the expected combinational req_ready
        // before the edge, and the expected registered outputs after it.
        vecs[0]  = '{4'b1111, DEF_A, DEF_B, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h05, 8'h5A, 4'd1};
        vecs[1]  = '{4'b0000, DEF_A, DEF_B, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h05, 8'h5A, 4'd1};
        vecs[2]  = '{4'b0100, SP_A,  SP_B,  1'b1, 4'b0100, 1'b1, 2'd2, 8'h30, 8'hCC, 4'd2};
        vecs[3]  = '{4'b0000, DEF_A, DEF_B, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h30, 8'hCC, 4'd2};
        vecs[4]  = '{4'b1111, DEF_A, DEF_B, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h15, 8'h6A, 4'd3};
        vecs[5]  = '{4'b1111, DEF_A, DEF_B, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h05, 8'h5A, 4'd4};
        vecs[6]  = '{4'b1111, DEF_A, DEF_B, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h15, 8'h4A, 4'd5};
        vecs[7]  = '{4'b1111, DEF_A, DEF_B, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h05, 8'h7A, 4'd6};
        vecs[8]  = '{4'b1111, DEF_A, DEF_B, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h15, 8'h6A, 4'd7};
        vecs[9]  = '{4'b1111, DEF_A, DEF_B, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h05, 8'h5A, 4'd8};
        vecs[10] = '{4'b1111, DEF_A, DEF_B, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h15, 8'h4A, 4'd9};
        vecs[11] = '{4'b1111, DEF_A, DEF_B, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h15, 8'h4A, 4'd9};
        vecs[12] = '{4'b1111, DEF_A, DEF_B, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h15, 8'h4A, 4'd9};
        vecs[13] = '{4'b1111, DEF_A, DEF_B, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h15, 8'h4A, 4'd9};
        vecs[14] = '{4'b1111, DEF_A, DEF_B, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h05, 8'h7A, 4'd10};
        vecs[15] = '{4'b1000, DEF_A, DEF_B, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h15, 8'h6A, 4'd11};
        vecs[16] = '{4'b1010, DEF_A, DEF_B, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h15, 8'h4A, 4'd12};
        vecs[17] = '{4'b1010, DEF_A, DEF_B, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h15, 8'h6A, 4'd13};
        vecs[18] = '{4'b1010, DEF_A, DEF_B, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h15, 8'h4A, 4'd14};
        vecs[19] = '{4'b0000, DEF_A, DEF_B, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h15, 8'h4A, 4'd14};
        vecs[20] = '{4'b0000, DEF_A, DEF_B, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h15, 8'h4A, 4'd14};

        // Reset held with every requester asking: nothing may be accepted.
        reset = 1'b1;
        applyStimulus(4'b1111, DEF_A, DEF_B, 1'b1);
        @(posedge clock);
        #1;
        checkOutput("reset.req_ready", 32'(reqReady), 32'h0);
        checkOutput("reset.rsp_valid", 32'(rspValid), 32'h0);
        checkOutput("reset.grant_count", 32'(grantCount), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].rdy);
            #1;
            checkOutput($sformatf("row%0d.req_ready", i), 32'(reqReady),
                        32'(vecs[i].expReady));
            @(posedge clock);
            #1;
            checkRsp($sformatf("row%0d", i), vecs[i].expValid, vecs[i].expId,
                     vecs[i].expAnd, vecs[i].expXor, vecs[i].expCount);
        end

        // Mid-operation reset: load a response, then assert reset between edges.
        applyStimulus(4'b0001, DEF_A, DEF_B, 1'b1);
        #1;
        checkOutput("midrst.pre_ready", 32'(reqReady), 32'h1);
        @(posedge clock);
        #1;
        checkRsp("midrst.pre", 1'b1, 2'd0, 8'h05, 8'h5A, 4'd15);
        #2;
        reset = 1'b1;
        #1;
        checkRsp("midrst.async", 1'b0, 2'd0, 8'h00, 8'h00, 4'd0);
        checkOutput("midrst.req_ready", 32'(reqReady), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(4'b1000, DEF_A, DEF_B, 1'b1);
        #1;
        checkOutput("midrst.post_ready", 32'(reqReady), 32'h8);
        @(posedge clock);
        #1;
        checkRsp("midrst.post", 1'b1, 2'd3, 8'h15, 8'h6A, 4'd1);

        // Lone requester granted every cycle; counter wraps 15 -> 0.
        applyStimulus(4'b0001, DEF_A, DEF_B, 1'b1);
        for (int k = 0; k < 15; k++) begin
            #1;
            checkOutput($sformatf("lone%0d.req_ready", k), 32'(reqReady), 32'h1);
            @(posedge clock);
            #1;
            checkOutput($sformatf("lone%0d.grant_count", k), 32'(grantCount),
                        32'((k + 2) % 16));
        end
        checkRsp("wrap", 1'b1, 2'd0, 8'h05, 8'h5A, 4'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one registered bitwise AND/XOR logic unit between NUM_REQ independent requesters.
- Sits between the board-level stimulus sources (switch debouncers, UART command decoder, self-test sequencer) and the shared logic unit.
- Arbitrates round-robin, accepts one operand pair per cycle, returns results tagged with the requester ID over a single valid/ready response channel with backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand and result width in bits.
- CNT_W, 16, width of the grant counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand-valid.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing.
- req_ready  out  NUM_REQ  one-hot accept strobe; all zero when nothing is accepted.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  downstream accepts the response.
- rsp_id  out  $clog2(NUM_REQ)  ID of the requester that owns the response.
- rsp_and  out  WIDTH  a & b.
- rsp_xor  out  WIDTH  a ^ b.
- grant_count  out  CNT_W  total accepted requests since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset, asynchronous, effective immediately:
  - rsp_valid=0, rsp_id=0, rsp_and=0, rsp_xor=0, grant_count=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
  - req_ready is combinational and reads 0 while rst=1.
- slot_free = !rsp_valid || rsp_ready.
- Grant, combinational:
  - If slot_free and |req_valid, pick the first set req_valid bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - Drive req_ready[g]=1 for the picked requester only.
  - If !slot_free or req_valid==0, req_ready is all zero.
- On a clock edge with a grant g:
  - Register rsp_and=req_a[g]&req_b[g], rsp_xor=req_a[g]^req_b[g], rsp_id=g.
  - Set rsp_valid=1, last_grant=g, grant_count+=1.
  - Latency is exactly one cycle from acceptance to rsp_valid.
- On a clock edge with no grant and rsp_valid && rsp_ready: rsp_valid=0. Data fields hold their last values.
- Simultaneous drain and grant, i.e. rsp_valid && rsp_ready with a new grant in the same cycle: the new result replaces the old one and rsp_valid stays 1. Sustained throughput is 1 result per cycle.
- Backpressure (rsp_valid && !rsp_ready):
  - rsp_id, rsp_and and rsp_xor hold stable.
  - No grant is issued; last_grant and grant_count are frozen.
- Requester rules:
  - Requesters keep req_valid and operands stable until their req_ready pulse.
  - The arbiter samples operands only in the grant cycle.
  - A requester dropping req_valid before it is granted is legal; it is simply skipped.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants. A lone requester is granted every free cycle.
- grant_count wraps from 2^CNT_W-1 to 0 without any flag.
- Reset asserted mid-burst discards the in-flight response. The first grant after release goes to the lowest-index valid requester.
- No combinational path from rsp_ready to rsp_valid. Paths from rsp_ready and req_valid to req_ready are permitted.

Decomposition:
- Package logic_unit_pkg holds:
  - the default NUM_REQ/WIDTH constants;
  - an ID-width localparam helper;
  - the typedef struct lu_rsp_t {id, and_r, xor_r}, used for the response register.
- One sub-module, lu_rr_pick:
  - Parameterised NUM_REQ.
  - Inputs: req vector and last_grant.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational, rotate-priority-rotate-back.
- The top level holds the response register, pointer, counter and the operand mux.

Test Plan (NUM_REQ=4, WIDTH=8):
- Reset: hold rst=1 with all req_valid=1 -> req_ready=0000, rsp_valid=0, grant_count=0. Release -> first edge grants ID 0.
- Single request: req_valid=0100, a2=0xF0, b2=0x3C, rsp_ready=1 -> req_ready=0100 for one cycle. Next cycle rsp_valid=1, rsp_id=2, rsp_and=0x30, rsp_xor=0xCC, grant_count=1.
- Full contention: req_valid=1111 held, rsp_ready=1 -> grant sequence 0,1,2,3,0,1 on consecutive cycles, rsp_valid continuously 1, grant_count 1..6.
- Backpressure: after a grant to ID 1, hold rsp_ready=0 for 3 cycles with req_valid=1111 -> rsp fields stable, req_ready=0000, count frozen. Raise rsp_ready -> same cycle req_ready=0100, next response rsp_id=2.
- Sparse wrap: last_grant=3, req_valid=1010 -> ID 1 granted, then ID 3, then ID 1.
- Reset mid-operation: assert rst asynchronously between edges while rsp_valid=1 -> rsp_valid and grant_count drop to 0 immediately. After release with req_valid=1000 -> ID 3 granted, rsp_id=3.
